// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART frame sequencer.
// State encoding plus the default header and ASCII offset bytes.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4,
        S_DRAIN = 3'd5
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam logic [7:0] ASCII_BASE_DEF = 8'h30;

endpackage

// File: rtl/uart_frame_ctrl_sync_edge.sv
// Two-flop synchroniser for slow-domain status levels.
// EDGE=1 turns the output into a one-cycle rising-edge pulse.
module sync_edge #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // two metastability-hardening stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic s3_q;

            // previous synchronised level for rising-edge detection
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s3_q <= 1'b0;
                end else begin
                    s3_q <= s2_q;
                end
            end

            assign q_o = s2_q & ~s3_q;
        end else begin : g_lvl
            assign q_o = s2_q;
        end
    endgenerate

endmodule

// File: rtl/uart_frame_ctrl.sv
// Sequencer between the UART pair and the inference core: hunts a
// header byte, loads a pixel frame, runs the core, returns ASCII digit.
module uart_frame_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned N_PIX      = 784,
    parameter int unsigned ADDR_W     = 10,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT    = 5_000_000,
    parameter logic [7:0]  ASCII_BASE = ASCII_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_wdata,
    output logic              nn_start,
    input  logic              nn_done,
    input  logic [3:0]        nn_result,
    output logic              busy,
    output logic              err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic rx_ev;
    logic busy_s;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              pix_we_q, pix_we_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [7:0]        pix_wdata_q, pix_wdata_d;
    logic              nn_start_q, nn_start_d;
    logic              tx_en_q, tx_en_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              err_q, err_d;

    sync_edge #(.EDGE(1'b1)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_rdy),
        .q_o (rx_ev)
    );

    sync_edge #(.EDGE(1'b0)) u_tx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (tx_busy),
        .q_o (busy_s)
    );

    // next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tmo_d       = tmo_q;
        pix_we_d    = 1'b0;
        pix_addr_d  = pix_addr_q;
        pix_wdata_d = pix_wdata_q;
        nn_start_d  = 1'b0;
        tx_en_d     = 1'b0;
        tx_data_d   = tx_data_q;
        err_d       = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (rx_ev && rx_data == SYNC_BYTE) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (rx_ev) begin
                    pix_we_d    = 1'b1;
                    pix_addr_d  = addr_q;
                    pix_wdata_d = rx_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    tmo_d       = '0;
                    if (addr_q == LAST) begin
                        state_d = S_START;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_START: begin
                nn_start_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (nn_done) begin
                    tx_data_d = ASCII_BASE + {4'd0, nn_result};
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                tx_en_d = tx_en_q;
                if (!tx_en_q && !busy_s) begin
                    tx_en_d = 1'b1;
                end else if (tx_en_q && busy_s) begin
                    tx_en_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!busy_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state, counters and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            tmo_q       <= '0;
            pix_we_q    <= 1'b0;
            pix_addr_q  <= '0;
            pix_wdata_q <= '0;
            nn_start_q  <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tmo_q       <= tmo_d;
            pix_we_q    <= pix_we_d;
            pix_addr_q  <= pix_addr_d;
            pix_wdata_q <= pix_wdata_d;
            nn_start_q  <= nn_start_d;
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
        end
    end

    assign tx_en     = tx_en_q;
    assign tx_data   = tx_data_q;
    assign pix_we    = pix_we_q;
    assign pix_addr  = pix_addr_q;
    assign pix_wdata = pix_wdata_q;
    assign nn_start  = nn_start_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomised frame-level bench for uart_frame_ctrl with an
// emulated slow transmitter and a scoreboard of expected writes.
module tb_uart_frame_ctrl;

    localparam int N_PIX   = 784;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 200;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ABASE = 8'h30;

    logic              clk;
    logic              rst;
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        pix_wdata;
    logic              nn_start;
    logic              nn_done;
    logic [3:0]        nn_result;
    logic              busy;
    logic              err;

    uart_frame_ctrl #(
        .N_PIX   (N_PIX),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .pix_we    (pix_we),
        .pix_addr  (pix_addr),
        .pix_wdata (pix_wdata),
        .nn_start  (nn_start),
        .nn_done   (nn_done),
        .nn_result (nn_result),
        .busy      (busy),
        .err       (err)
    );

    int n_chk;
    int n_err;

    logic [ADDR_W-1:0] got_a[$];
    logic [7:0]        got_d[$];
    logic [7:0]        exp_d[$];
    int                start_cnt;
    int                tx_cnt;
    logic [7:0]        tx_last;
    logic              tx_en_prev;
    logic              tx_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // observe DUT outputs away from the active edge
    always @(negedge clk) begin
        if (pix_we) begin
            got_a.push_back(pix_addr);
            got_d.push_back(pix_wdata);
        end
        if (nn_start) start_cnt++;
        if (tx_en && !tx_en_prev) begin
            tx_cnt++;
            tx_last = tx_data;
        end
        tx_en_prev = tx_en;
    end

    // slow transmitter: answers tx_en with a busy burst
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_force) begin
                tx_busy = 1'b1;
            end else if (tx_en) begin
                repeat (3) @(negedge clk);
                tx_busy = 1'b1;
                repeat (10) @(negedge clk);
                tx_busy = 1'b0;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        repeat (4) @(negedge clk);
        rx_rdy = 1'b0;
        repeat ($urandom_range(2, 6)) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_a.delete();
        got_d.delete();
        exp_d.delete();
        start_cnt = 0;
        tx_cnt    = 0;
    endtask

    task automatic frame(input logic [3:0] res, input bit ramp,
                         input bit stress);
        int t;
        logic [7:0] d;
        clear_obs();
        send_byte(SYNC);
        for (int i = 0; i < N_PIX; i++) begin
            d = ramp ? 8'(i % 256) : 8'($urandom_range(0, 255));
            exp_d.push_back(d);
            send_byte(d);
        end
        t = 0;
        while (start_cnt == 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", 32'(start_cnt), 32'd1);
        if (stress) begin
            send_byte(SYNC);
            send_byte(8'($urandom_range(0, 255)));
            send_byte(8'($urandom_range(0, 255)));
            tx_force = 1'b1;
            repeat (60) @(negedge clk);
        end else begin
            repeat (100) @(negedge clk);
        end
        nn_result = res;
        nn_done   = 1'b1;
        @(negedge clk);
        nn_done   = 1'b0;
        nn_result = 4'($urandom_range(0, 15));
        if (stress) begin
            send_byte(SYNC);
            send_byte(8'($urandom_range(0, 255)));
            repeat (40) @(negedge clk);
            check("tx_hold", 32'(tx_en), 32'd0);
            check("tx_hold_cnt", 32'(tx_cnt), 32'd0);
            tx_force = 1'b0;
        end
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        check("wr_count", 32'(got_a.size()), 32'(N_PIX));
        for (int i = 0; i < N_PIX && i < got_a.size(); i++) begin
            check("wr_entry", {14'd0, got_a[i], got_d[i]},
                  {14'd0, 10'(i), exp_d[i]});
        end
        check("start_count", 32'(start_cnt), 32'd1);
        check("tx_count", 32'(tx_cnt), 32'd1);
        check("tx_byte", 32'(tx_last), 32'(ABASE + 8'(res)));
        check("tx_data_hold", 32'(tx_data), 32'(ABASE + 8'(res)));
        check("err_clear", 32'(err), 32'd0);
    endtask

    initial begin
        int t;
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b0;
        rx_rdy    = 1'b0;
        rx_data   = 8'h00;
        nn_done   = 1'b0;
        nn_result = 4'd0;
        tx_force  = 1'b0;
        tx_en_prev = 1'b0;
        clear_obs();
        repeat (3) @(negedge clk);
        check("reset_out",
              {7'd0, tx_en, pix_we, nn_start, busy, err,
               tx_data, pix_addr, pix_wdata}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // nominal ramp frame, digit 7
        frame(4'd7, 1'b1, 1'b0);

        // garbage ahead of the header is ignored
        clear_obs();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'($urandom_range(0, 255)) == SYNC ? 8'h11
                      : 8'($urandom_range(0, 255)));
        end
        check("garbage_wr", 32'(got_a.size()), 32'd0);
        check("garbage_busy", 32'(busy), 32'd0);
        frame(4'($urandom_range(0, 9)), 1'b0, 1'b0);

        // timeout after a short partial frame
        clear_obs();
        send_byte(SYNC);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
        t = 0;
        while (busy && t < TIMEOUT + 100) begin
            @(negedge clk);
            t++;
        end
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_wr", 32'(got_a.size()), 32'd10);
        repeat (20) @(negedge clk);
        check("tmo_nostart", 32'(start_cnt), 32'd0);
        send_byte(8'h3C);
        check("err_sticky", 32'(err), 32'd1);

        // header clears err, then reset lands mid-load at address 400
        clear_obs();
        send_byte(SYNC);
        check("sync_clr_err", 32'(err), 32'd0);
        check("sync_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 400; i++) send_byte(8'($urandom_range(0, 255)));
        check("pre_rst_wr", 32'(got_a.size()), 32'd400);
        rst = 1'b0;
        #1;
        check("mid_rst_out",
              {7'd0, tx_en, pix_we, nn_start, busy, err,
               tx_data, pix_addr, pix_wdata}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_start", 32'(start_cnt), 32'd0);
        check("post_rst_tx", 32'(tx_cnt), 32'd0);

        // busy transmitter plus stray bytes during WAIT and SEND
        frame(4'd3, 1'b0, 1'b1);

        // next frame must start cleanly at address 0
        frame(4'($urandom_range(0, 9)), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
